// File: rtl/seven_segment_pkg.sv
// Shared seven-segment encoding and checker state type, used by the checker
// and by the seven_segment_seconds pattern generator.
package seven_segment_pkg;

   localparam int NUM_DIGITS = 10;

   // Segment codes indexed by digit value; bit0 = a ... bit6 = g, active-high.
   localparam logic [NUM_DIGITS-1:0][6:0] SEG_TABLE = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      LOCKED = 2'd1,
      TIMING = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] value;
   } decode_t;

   function automatic decode_t seg_decode(input logic [6:0] pat);
      decode_t r;
      r.valid = 1'b0;
      r.value = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (pat == SEG_TABLE[i]) begin
            r.valid = 1'b1;
            r.value = 4'(i);
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] r;
      r = 7'h00;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (d == 4'(i)) r = SEG_TABLE[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_debounce.sv
// Two-flop synchronizer followed by a stability filter: a pattern is reported
// once it has held for STABLE_CYCLES samples and differs from the last one reported.
module seg_debounce #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   output logic [6:0] pattern,
   output logic       new_pat
);

   localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

   logic [6:0] seg_p0;
   logic [6:0] seg_p1;
   logic [6:0] cand;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt + 4'd1;
      if (seg_p1 != cand) begin
         cnt_nxt = 4'd1;
      end else if (cnt >= STABLE_N) begin
         cnt_nxt = STABLE_N;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_p0  <= 7'h00;
         seg_p1  <= 7'h00;
         cand    <= 7'h00;
         cnt     <= 4'd0;
         pattern <= 7'h00;
         new_pat <= 1'b0;
      end else begin
         seg_p0  <= seg_in;
         seg_p1  <= seg_p0;
         // stage boundary: synchronized sample feeds the stability filter
         cand    <= seg_p1;
         cnt     <= cnt_nxt;
         new_pat <= 1'b0;
         if ((cnt_nxt == STABLE_N) && (seg_p1 != pattern)) begin
            pattern <= seg_p1;
            new_pat <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_segment_checker.sv
// Monitors a seven-segment seconds display: decodes stable digits, checks the
// count sequence and step timing, and counts 9->0 wraps.
module seven_segment_checker
   import seven_segment_pkg::*;
#(
   parameter int MAX_COUNT     = 16_000_000,
   parameter int STABLE_CYCLES = 4,
   parameter int TOL           = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   output logic [3:0] digit,
   output logic       digit_valid,
   output logic       step,
   output logic       err_seq,
   output logic       err_code,
   output logic       err_period,
   output logic [7:0] wraps
);

   localparam int CW = $clog2(MAX_COUNT + TOL + 1) + 1;
   localparam logic [CW:0] LO_LIM    = (CW+1)'(MAX_COUNT - TOL);
   localparam logic [CW:0] HI_LIM    = (CW+1)'(MAX_COUNT + TOL);
   localparam logic [CW:0] STALL_LIM = (CW+1)'(MAX_COUNT + TOL + 1);

   logic [6:0]    pattern;
   logic          new_pat;
   decode_t       dec;
   logic          accept;
   logic [3:0]    next_digit;
   logic [CW-1:0] ivl_cnt;
   logic [CW:0]   elapsed;
   state_t        state;

   seg_debounce #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .seg_in  (seg_in),
      .pattern (pattern),
      .new_pat (new_pat)
   );

   assign dec        = seg_decode(pattern);
   assign accept     = new_pat && dec.valid;
   assign next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
   // Interval length if a step landed on this edge.
   assign elapsed    = {1'b0, ivl_cnt} + (CW+1)'(1);

   // stage boundary: accepted pattern -> decoded digit, checks and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SEARCH;
         digit       <= 4'd0;
         digit_valid <= 1'b0;
         step        <= 1'b0;
         err_seq     <= 1'b0;
         err_code    <= 1'b0;
         err_period  <= 1'b0;
         wraps       <= 8'd0;
         ivl_cnt     <= '0;
      end else begin
         step <= 1'b0;
         if (ivl_cnt != '1) ivl_cnt <= ivl_cnt + CW'(1);
         if (new_pat && !dec.valid) err_code <= 1'b1;

         if (accept) begin
            step        <= 1'b1;
            digit       <= dec.value;
            digit_valid <= 1'b1;
            ivl_cnt     <= '0;
            case (state)
               SEARCH:  state <= LOCKED;
               default: state <= TIMING;
            endcase
            if (state != SEARCH) begin
               if ((digit == 4'd9) && (dec.value == 4'd0)) begin
                  wraps <= wraps + 8'd1;
               end else if (dec.value != next_digit) begin
                  err_seq <= 1'b1;
               end
            end
            if ((state == TIMING) && ((elapsed < LO_LIM) || (elapsed > HI_LIM))) begin
               err_period <= 1'b1;
            end
         end else if ((state == TIMING) && (elapsed == STALL_LIM)) begin
            // Step is overdue: flag the stall once, as the limit is crossed.
            err_period <= 1'b1;
         end
      end
   end

endmodule
